// File: rtl/calc_pkg.sv
// Shared types and constants for the calc sequencer: FSM states, ALU opcodes,
// 32-bit record field layout and memory direction encodings.
package calc_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_EXEC      = 3'd1,
    ST_WRITE     = 3'd2,
    ST_READ      = 3'd3,
    ST_READ_WAIT = 3'd4,
    ST_DONE      = 3'd5
  } calc_state_t;

  localparam logic [3:0] OP_ADD  = 4'h0;
  localparam logic [3:0] OP_SUB  = 4'h1;
  localparam logic [3:0] OP_INC  = 4'h2;
  localparam logic [3:0] OP_DEC  = 4'h3;
  localparam logic [3:0] OP_SHL  = 4'h4;
  localparam logic [3:0] OP_SHR  = 4'h5;
  localparam logic [3:0] OP_AND  = 4'h6;
  localparam logic [3:0] OP_OR   = 4'h7;
  localparam logic [3:0] OP_XOR  = 4'h8;
  localparam logic [3:0] OP_NOT  = 4'h9;
  localparam logic [3:0] OP_NAND = 4'hA;
  localparam logic [3:0] OP_NOR  = 4'hB;

  localparam int REC_WIDTH    = 32;
  localparam int REC_A_LSB    = 0;
  localparam int REC_A_W      = 8;
  localparam int REC_B_LSB    = 8;
  localparam int REC_B_W      = 8;
  localparam int REC_OUT_LSB  = 16;
  localparam int REC_OUT_W    = 8;
  localparam int REC_SEL_LSB  = 24;
  localparam int REC_SEL_W    = 4;
  localparam int REC_FLAG_LSB = 28;
  localparam int REC_FLAG_W   = 4;

  localparam logic MEM_WRITE = 1'b1;
  localparam logic MEM_READ  = 1'b0;

  function automatic logic [REC_WIDTH-1:0] pack_record(
    input logic [REC_FLAG_W-1:0] flag,
    input logic [REC_SEL_W-1:0]  sel,
    input logic [REC_OUT_W-1:0]  res,
    input logic [REC_B_W-1:0]    b,
    input logic [REC_A_W-1:0]    a
  );
    logic [REC_WIDTH-1:0] rec;
    rec = '0;
    rec[REC_FLAG_LSB +: REC_FLAG_W] = flag;
    rec[REC_SEL_LSB  +: REC_SEL_W]  = sel;
    rec[REC_OUT_LSB  +: REC_OUT_W]  = res;
    rec[REC_B_LSB    +: REC_B_W]    = b;
    rec[REC_A_LSB    +: REC_A_W]    = a;
    return rec;
  endfunction

endpackage

// File: rtl/calc_wr_pointer.sv
// Record write pointer: increments by one per accepted write, wraps modulo 2^WIDTH,
// and raises a sticky flag the first time it wraps; cleared only by reset.
module calc_wr_pointer #(
  parameter int WIDTH = 8
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             i_inc,
  output logic [WIDTH-1:0] o_ptr,
  output logic             o_wrapped
);

  logic [WIDTH-1:0] r_ptr;
  logic             r_wrapped;

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      r_ptr     <= '0;
      r_wrapped <= 1'b0;
    end else if (i_inc) begin
      r_ptr <= r_ptr + WIDTH'(1);
      if (&r_ptr) r_wrapped <= 1'b1;
    end
  end

  assign o_ptr     = r_ptr;
  assign o_wrapped = r_wrapped;

endmodule

// File: rtl/calc_sequencer.sv
// Drives the ALU, logs {flag,sel,out,b,a} records to memory at an auto-incrementing
// pointer, or reads one back; Start to Done is 3 cycles, Start while Busy is dropped.
module calc_sequencer
  import calc_pkg::*;
#(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32,
  parameter int OP_WIDTH   = 8
) (
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic                  Start,
  input  logic                  Mode,
  input  logic [OP_WIDTH-1:0]   InA,
  input  logic [OP_WIDTH-1:0]   InB,
  input  logic [3:0]            InSel,
  input  logic [ADDR_WIDTH-1:0] RdAddr,
  output logic [OP_WIDTH-1:0]   AluA,
  output logic [OP_WIDTH-1:0]   AluB,
  output logic [3:0]            AluSel,
  input  logic [OP_WIDTH-1:0]   AluOut,
  input  logic [3:0]            AluFlag,
  output logic [DATA_WIDTH-1:0] MemDin,
  output logic [ADDR_WIDTH-1:0] MemAddr,
  output logic                  MemR_W,
  output logic                  MemValid,
  input  logic [DATA_WIDTH-1:0] MemDout,
  output logic                  Busy,
  output logic                  Done,
  output logic [OP_WIDTH-1:0]   ResultOut,
  output logic [3:0]            FlagOut,
  output logic [DATA_WIDTH-1:0] RecordOut,
  output logic [ADDR_WIDTH-1:0] WrPtr,
  output logic                  Wrapped
);

  calc_state_t           r_state;
  logic [OP_WIDTH-1:0]   r_alu_a;
  logic [OP_WIDTH-1:0]   r_alu_b;
  logic [3:0]            r_alu_sel;
  logic [DATA_WIDTH-1:0] r_mem_din;
  logic [ADDR_WIDTH-1:0] r_mem_addr;
  logic [OP_WIDTH-1:0]   r_result;
  logic [3:0]            r_flag;
  logic [DATA_WIDTH-1:0] r_record;

  logic [ADDR_WIDTH-1:0] w_wr_ptr;
  logic                  w_wrapped;
  logic                  w_ptr_inc;

  assign w_ptr_inc = (r_state == ST_WRITE);

  calc_wr_pointer #(.WIDTH(ADDR_WIDTH)) u_wr_pointer (
    .Clk       (Clk),
    .Reset     (Reset),
    .i_inc     (w_ptr_inc),
    .o_ptr     (w_wr_ptr),
    .o_wrapped (w_wrapped)
  );

  // Strobes come straight off the state register, so an async reset kills them at once.
  assign MemValid = (r_state == ST_WRITE) || (r_state == ST_READ);
  assign MemR_W   = (r_state == ST_WRITE) ? MEM_WRITE : MEM_READ;
  assign Busy     = (r_state != ST_IDLE);
  assign Done     = (r_state == ST_DONE);

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      r_state    <= ST_IDLE;
      r_alu_a    <= '0;
      r_alu_b    <= '0;
      r_alu_sel  <= '0;
      r_mem_din  <= '0;
      r_mem_addr <= '0;
      r_result   <= '0;
      r_flag     <= '0;
      r_record   <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (Start) begin
            if (Mode) begin
              r_mem_addr <= RdAddr;
              r_state    <= ST_READ;
            end else begin
              r_alu_a   <= InA;
              r_alu_b   <= InB;
              r_alu_sel <= InSel;
              r_state   <= ST_EXEC;
            end
          end
        end
        ST_EXEC: begin
          r_result   <= AluOut;
          r_flag     <= AluFlag;
          r_mem_din  <= pack_record(AluFlag, r_alu_sel, AluOut, r_alu_b, r_alu_a);
          r_mem_addr <= w_wr_ptr;
          r_state    <= ST_WRITE;
        end
        ST_WRITE: begin
          r_record <= r_mem_din;
          r_state  <= ST_DONE;
        end
        ST_READ: begin
          r_state <= ST_READ_WAIT;
        end
        ST_READ_WAIT: begin
          r_record <= MemDout;
          r_result <= MemDout[REC_OUT_LSB +: REC_OUT_W];
          r_flag   <= MemDout[REC_FLAG_LSB +: REC_FLAG_W];
          r_state  <= ST_DONE;
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign AluA      = r_alu_a;
  assign AluB      = r_alu_b;
  assign AluSel    = r_alu_sel;
  assign MemDin    = r_mem_din;
  assign MemAddr   = r_mem_addr;
  assign ResultOut = r_result;
  assign FlagOut   = r_flag;
  assign RecordOut = r_record;
  assign WrPtr     = w_wr_ptr;
  assign Wrapped   = w_wrapped;

endmodule

// File: tb/tb_calc_sequencer.sv
// Bench for calc_sequencer: ALU stub, one-cycle-latency memory model, directed
// vector table for compute/readback plus sequences for busy, wrap, reset and back-to-back.
module tb_calc_sequencer;
  import calc_pkg::*;

  logic        Clk;
  logic        Reset;
  logic        Start;
  logic        Mode;
  logic [7:0]  InA;
  logic [7:0]  InB;
  logic [3:0]  InSel;
  logic [7:0]  RdAddr;
  logic [7:0]  AluA;
  logic [7:0]  AluB;
  logic [3:0]  AluSel;
  logic [7:0]  AluOut;
  logic [3:0]  AluFlag;
  logic [31:0] MemDin;
  logic [7:0]  MemAddr;
  logic        MemR_W;
  logic        MemValid;
  logic [31:0] MemDout;
  logic        Busy;
  logic        Done;
  logic [7:0]  ResultOut;
  logic [3:0]  FlagOut;
  logic [31:0] RecordOut;
  logic [7:0]  WrPtr;
  logic        Wrapped;

  calc_sequencer dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .Mode(Mode),
    .InA(InA), .InB(InB), .InSel(InSel), .RdAddr(RdAddr),
    .AluA(AluA), .AluB(AluB), .AluSel(AluSel),
    .AluOut(AluOut), .AluFlag(AluFlag),
    .MemDin(MemDin), .MemAddr(MemAddr), .MemR_W(MemR_W), .MemValid(MemValid),
    .MemDout(MemDout), .Busy(Busy), .Done(Done),
    .ResultOut(ResultOut), .FlagOut(FlagOut), .RecordOut(RecordOut),
    .WrPtr(WrPtr), .Wrapped(Wrapped)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // ALU stub; flags = {0, 0, negative, zero}
  always_comb begin
    AluOut = 8'h00;
    case (AluSel)
      OP_ADD:  AluOut = AluA + AluB;
      OP_SUB:  AluOut = AluA - AluB;
      OP_AND:  AluOut = AluA & AluB;
      OP_OR:   AluOut = AluA | AluB;
      OP_XOR:  AluOut = AluA ^ AluB;
      default: AluOut = 8'h00;
    endcase
    AluFlag = {2'b00, AluOut[7], (AluOut == 8'h00)};
  end

  logic [31:0] mem [256];
  int          wr_cnt = 0;
  int          rd_cnt = 0;
  logic [7:0]  last_wr_addr = '0;
  logic [31:0] last_wr_data = '0;
  logic [7:0]  last_rd_addr = '0;
  logic [7:0]  wr_hist[$];

  initial MemDout = '0;

  always @(posedge Clk) begin
    if (MemValid === 1'b1) begin
      if (MemR_W) begin
        mem[MemAddr] <= MemDin;
        wr_cnt       <= wr_cnt + 1;
        last_wr_addr <= MemAddr;
        last_wr_data <= MemDin;
        wr_hist.push_back(MemAddr);
      end else begin
        MemDout      <= mem[MemAddr];
        rd_cnt       <= rd_cnt + 1;
        last_rd_addr <= MemAddr;
      end
    end
  end

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Issues one request; lat = falling edges from the sampling edge until Done (10 = timeout).
  task automatic do_op(input logic mode, input logic [7:0] a, input logic [7:0] b,
                       input logic [3:0] sel, input logic [7:0] ra, output int lat);
    @(negedge Clk);
    Start = 1'b1; Mode = mode; InA = a; InB = b; InSel = sel; RdAddr = ra;
    @(posedge Clk);
    @(negedge Clk);
    Start = 1'b0; InA = ~a; InB = ~b; InSel = ~sel; RdAddr = ~ra;
    lat = 1;
    while (!Done && lat < 10) begin
      @(negedge Clk);
      lat++;
    end
  endtask

  typedef struct {
    logic [7:0]  a;
    logic [7:0]  b;
    logic [3:0]  sel;
    logic [7:0]  exp_out;
    logic [3:0]  exp_flag;
    logic [31:0] exp_rec;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int lat;
    int wc;
    int rc;
    int cyc;
    int nd;
    int dcyc[3];

    vecs[0] = '{8'hF0, 8'h3C, OP_AND, 8'h30, 4'h0, 32'h06303CF0};
    vecs[1] = '{8'h10, 8'h20, OP_ADD, 8'h30, 4'h0, 32'h00302010};
    vecs[2] = '{8'h05, 8'h07, OP_SUB, 8'hFE, 4'h2, 32'h21FE0705};
    vecs[3] = '{8'h0F, 8'hF0, OP_XOR, 8'hFF, 4'h2, 32'h28FFF00F};
    vecs[4] = '{8'hAA, 8'h55, OP_OR,  8'hFF, 4'h2, 32'h27FF55AA};
    vecs[5] = '{8'h33, 8'h33, OP_XOR, 8'h00, 4'h1, 32'h18003333};

    Reset = 1'b0; Start = 1'b0; Mode = 1'b0;
    InA = '0; InB = '0; InSel = '0; RdAddr = '0;
    #12;
    check("rst_busy", Busy, 1'b0);
    check("rst_done", Done, 1'b0);
    check("rst_memvalid", MemValid, 1'b0);
    check("rst_memrw", MemR_W, 1'b0);
    check("rst_alu", {AluA, AluB, AluSel}, 20'h0);
    check("rst_mem", MemDin | {24'h0, MemAddr}, 32'h0);
    check("rst_result", {ResultOut, FlagOut, WrPtr, Wrapped}, 32'h0);
    check("rst_record", RecordOut, 32'h0);
    @(negedge Clk);
    Reset = 1'b1;

    // Compute vectors, written to consecutive addresses from 0
    for (int i = 0; i < 6; i++) begin
      wc = wr_cnt;
      do_op(1'b0, vecs[i].a, vecs[i].b, vecs[i].sel, 8'h00, lat);
      check($sformatf("wr_latency[%0d]", i), lat, 3);
      check($sformatf("wr_count[%0d]", i), wr_cnt - wc, 1);
      check($sformatf("wr_addr[%0d]", i), last_wr_addr, i);
      check($sformatf("wr_data[%0d]", i), last_wr_data, vecs[i].exp_rec);
      check($sformatf("wr_result[%0d]", i), ResultOut, vecs[i].exp_out);
      check($sformatf("wr_flag[%0d]", i), FlagOut, vecs[i].exp_flag);
      check($sformatf("wr_record[%0d]", i), RecordOut, vecs[i].exp_rec);
      check($sformatf("wr_ptr[%0d]", i), WrPtr, i + 1);
      check($sformatf("wr_alua[%0d]", i), AluA, vecs[i].a);
    end

    // Readback of each stored record
    for (int i = 0; i < 6; i++) begin
      wc = wr_cnt; rc = rd_cnt;
      do_op(1'b1, 8'h00, 8'h00, 4'h0, i[7:0], lat);
      check($sformatf("rd_latency[%0d]", i), lat, 3);
      check($sformatf("rd_count[%0d]", i), rd_cnt - rc, 1);
      check($sformatf("rd_nowrite[%0d]", i), wr_cnt - wc, 0);
      check($sformatf("rd_addr[%0d]", i), last_rd_addr, i);
      check($sformatf("rd_record[%0d]", i), RecordOut, vecs[i].exp_rec);
      check($sformatf("rd_result[%0d]", i), ResultOut, vecs[i].exp_out);
      check($sformatf("rd_flag[%0d]", i), FlagOut, vecs[i].exp_flag);
      check($sformatf("rd_ptr[%0d]", i), {Wrapped, WrPtr}, 9'd6);
    end

    // Start during EXEC with other operands must be ignored
    wc = wr_cnt; rc = rd_cnt;
    @(negedge Clk);
    Start = 1'b1; Mode = 1'b0; InA = 8'h11; InB = 8'h22; InSel = OP_ADD;
    @(posedge Clk);
    @(negedge Clk);
    check("busy_in_exec", Busy, 1'b1);
    Start = 1'b1; Mode = 1'b1; InA = 8'h99; InB = 8'h88; InSel = OP_OR; RdAddr = 8'h02;
    @(negedge Clk);
    Start = 1'b0;
    @(negedge Clk);
    check("busy_done", Done, 1'b1);
    repeat (4) @(negedge Clk);
    check("busy_wr_count", wr_cnt - wc, 1);
    check("busy_rd_count", rd_cnt - rc, 0);
    check("busy_wr_addr", last_wr_addr, 8'd6);
    check("busy_wr_data", last_wr_data, 32'h00332211);
    check("busy_idle", Busy, 1'b0);

    // Fill to the wrap point: pointer is 7, 248 more writes reach 255
    for (int i = 0; i < 248; i++) begin
      do_op(1'b0, i[7:0], 8'h01, OP_ADD, 8'h00, lat);
      if (lat != 3) check("fill_latency", lat, 3);
    end
    check("pre_wrap_ptr", WrPtr, 8'd255);
    check("pre_wrap_flag", Wrapped, 1'b0);
    do_op(1'b0, 8'h01, 8'h02, OP_ADD, 8'h00, lat);
    check("wrap_wr_addr", last_wr_addr, 8'd255);
    check("wrap_ptr", WrPtr, 8'd0);
    check("wrap_flag", Wrapped, 1'b1);
    do_op(1'b0, 8'h12, 8'h34, OP_ADD, 8'h00, lat);
    check("post_wrap_wr_addr", last_wr_addr, 8'd0);
    check("post_wrap_wr_data", last_wr_data, 32'h00463412);
    check("post_wrap_ptr", {Wrapped, WrPtr}, 9'h101);
    do_op(1'b1, 8'h00, 8'h00, 4'h0, 8'h00, lat);
    check("wrap_rd_record", RecordOut, 32'h00463412);
    check("wrap_rd_ptr", {Wrapped, WrPtr}, 9'h101);

    // Reset asserted in the WRITE cycle
    wc = wr_cnt;
    @(negedge Clk);
    Start = 1'b1; Mode = 1'b0; InA = 8'h01; InB = 8'h01; InSel = OP_ADD;
    @(posedge Clk);
    @(negedge Clk);
    Start = 1'b0;
    @(negedge Clk);
    check("rstmid_write_strobe", {MemValid, MemR_W}, 2'b11);
    #2 Reset = 1'b0;
    #1;
    check("rstmid_memvalid", MemValid, 1'b0);
    check("rstmid_busy", Busy, 1'b0);
    check("rstmid_ptr", {Wrapped, WrPtr}, 9'h000);
    check("rstmid_outs", {ResultOut, FlagOut, AluA, AluB, AluSel}, 36'h0);
    check("rstmid_record", RecordOut | MemDin, 32'h0);
    @(negedge Clk);
    Reset = 1'b1;
    repeat (2) @(negedge Clk);
    check("rstmid_no_write", wr_cnt - wc, 0);
    check("rstmid_idle", {Busy, Done, MemValid}, 3'b000);

    // Start held high: one op per 4 cycles at addresses 0,1,2
    wc = wr_cnt;
    wr_hist.delete();
    nd = 0; cyc = 0;
    dcyc[0] = 0; dcyc[1] = 0; dcyc[2] = 0;
    @(negedge Clk);
    Start = 1'b1; Mode = 1'b0; InA = 8'h05; InB = 8'h03; InSel = OP_ADD;
    while (nd < 3 && cyc < 40) begin
      @(negedge Clk);
      cyc++;
      if (Done) begin
        dcyc[nd] = cyc;
        nd++;
        if (nd == 3) Start = 1'b0;
      end
    end
    Start = 1'b0;
    repeat (5) @(negedge Clk);
    check("held_done_count", nd, 3);
    check("held_first_done", dcyc[0], 3);
    check("held_gap_1", dcyc[1] - dcyc[0], 4);
    check("held_gap_2", dcyc[2] - dcyc[1], 4);
    check("held_wr_count", wr_cnt - wc, 3);
    for (int k = 0; k < 3; k++)
      check($sformatf("held_wr_addr[%0d]", k), (k < wr_hist.size()) ? wr_hist[k] : 8'hEE, k);
    check("held_ptr", WrPtr, 8'd3);
    check("held_record", RecordOut, 32'h00080305);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
